// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default polynomial, step function and checker state encoding.
package lfsr_pkg;

   localparam int LFSR_WIDTH = 20;
   localparam int LFSR_TAP_A = 19;
   localparam int LFSR_TAP_B = 16;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // x^20 + x^17 + 1: shift left, feed the XOR of the two taps into bit 0.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] w);
      return {w[LFSR_WIDTH-2:0], w[LFSR_TAP_A] ^ w[LFSR_TAP_B]};
   endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over a coincident increment.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the stream, locks after a run of matches,
// then flywheels its own prediction to count corrupted words.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int WIDTH      = LFSR_WIDTH,
   parameter int TAP_A      = LFSR_TAP_A,
   parameter int TAP_B      = LFSR_TAP_B,
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int CNT_W      = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    valid_i,
   input  logic signed [WIDTH-1:0] lfsr_i,
   input  logic                    clear_i,
   output logic                    locked_o,
   output logic                    error_o,
   output logic [CNT_W-1:0]        err_count_o,
   output logic [CNT_W-1:0]        word_count_o,
   output logic [1:0]              state_o
);

   localparam int MW = $clog2(((LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT) + 1);
   localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
   localparam logic [MW-1:0] LOSS_LAST = MW'(LOSS_COUNT - 1);

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w);
      return {w[WIDTH-2:0], w[TAP_A] ^ w[TAP_B]};
   endfunction

   chk_state_t        state_q;
   logic [WIDTH-1:0]  pred;
   logic [WIDTH-1:0]  word;
   logic [MW-1:0]     match_cnt;
   logic [MW-1:0]     miss_cnt;
   logic              hit;
   logic              word_inc;
   logic              err_inc;

   // Sign is irrelevant: the comparison is on raw bits.
   assign word     = lfsr_i;
   assign hit      = (word == pred);
   assign word_inc = valid_i && (state_q == LOCKED);
   assign err_inc  = word_inc && !hit;
   assign state_o  = state_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= HUNT;
         pred      <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked_o  <= 1'b0;
         error_o   <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch sees the pre-edge pred and counters.
         error_o <= 1'b0;
         case (state_q)
            HUNT: begin
               if (valid_i && (word != '0)) begin
                  pred      <= step(word);
                  match_cnt <= '0;
                  state_q   <= VERIFY;
               end
            end
            VERIFY: begin
               if (valid_i) begin
                  if (hit) begin
                     pred      <= step(word);
                     match_cnt <= match_cnt + 1'b1;
                     if (match_cnt == LOCK_LAST) begin
                        state_q  <= LOCKED;
                        locked_o <= 1'b1;
                        miss_cnt <= '0;
                     end
                  end else if (word != '0) begin
                     pred      <= step(word);
                     match_cnt <= '0;
                  end else begin
                     state_q <= HUNT;
                  end
               end
            end
            LOCKED: begin
               if (valid_i) begin
                  // Flywheel on our own prediction so a bad word cannot poison it.
                  pred <= step(pred);
                  if (hit) begin
                     miss_cnt <= '0;
                  end else begin
                     error_o  <= 1'b1;
                     miss_cnt <= miss_cnt + 1'b1;
                     if (miss_cnt == LOSS_LAST) begin
                        state_q  <= HUNT;
                        locked_o <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_q  <= HUNT;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (err_inc),
      .clr   (clear_i),
      .count (err_count_o)
   );

   sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (word_inc),
      .clr   (clear_i),
      .count (word_count_o)
   );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, flywheel, loss of lock, zero words, clear, gaps, reset.
module tb_lfsr_checker;

   logic        clock;
   logic        reset;
   logic        valid_i;
   logic [19:0] lfsr_i;
   logic        clear_i;
   logic        locked_o;
   logic        error_o;
   logic [31:0] err_count_o;
   logic [31:0] word_count_o;
   logic [1:0]  state_o;

   int          n_vec;
   int          n_err;
   logic [19:0] gen;

   lfsr_checker dut (
      .clock        (clock),
      .reset        (reset),
      .valid_i      (valid_i),
      .lfsr_i       (lfsr_i),
      .clear_i      (clear_i),
      .locked_o     (locked_o),
      .error_o      (error_o),
      .err_count_o  (err_count_o),
      .word_count_o (word_count_o),
      .state_o      (state_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] gen_step(input logic [19:0] w);
      return {w[18:0], w[19] ^ w[16]};
   endfunction

   // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
   task automatic apply(input logic v, input logic [19:0] w, input logic clr);
      valid_i = v;
      lfsr_i  = w;
      clear_i = clr;
      @(posedge clock);
      #1;
      valid_i = 1'b0;
      clear_i = 1'b0;
   endtask

   task automatic send_clean();
      apply(1'b1, gen, 1'b0);
      gen = gen_step(gen);
   endtask

   task automatic send_bad(input logic clr);
      apply(1'b1, gen ^ 20'h00001, clr);
      gen = gen_step(gen);
   endtask

   task automatic check_status(input string tag, input logic [1:0] st, input logic lk,
                               input logic er, input logic [31:0] ec, input logic [31:0] wc);
      check({tag, ".state"},  {30'd0, state_o}, {30'd0, st});
      check({tag, ".locked"}, {31'd0, locked_o}, {31'd0, lk});
      check({tag, ".error"},  {31'd0, error_o}, {31'd0, er});
      check({tag, ".errcnt"}, err_count_o, ec);
      check({tag, ".wrdcnt"}, word_count_o, wc);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b1;
      valid_i = 1'b0;
      lfsr_i  = '0;
      clear_i = 1'b0;
      gen     = 20'h00001;
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_status("reset", 2'd0, 1'b0, 1'b0, 0, 0);
      reset = 1'b1;

      // 1: 00001..00010, lock on the fifth word
      send_clean();
      check_status("t1.w1", 2'd1, 1'b0, 1'b0, 0, 0);
      for (int i = 2; i <= 4; i++) begin
         send_clean();
         check_status("t1.verify", 2'd1, 1'b0, 1'b0, 0, 0);
      end
      send_clean();
      check_status("t1.w5", 2'd2, 1'b1, 1'b0, 0, 0);
      check("t1.gen", {12'd0, gen}, 32'h00020);

      // 2: 00020 replaced by 00021, then 00040 must still match
      send_bad(1'b0);
      check_status("t2.bad", 2'd2, 1'b1, 1'b1, 1, 1);
      send_clean();
      check_status("t2.fly", 2'd2, 1'b1, 1'b0, 1, 2);

      // 3: clear, three corrupted words drop lock, clean stream relocks
      apply(1'b0, 20'hFFFFF, 1'b1);
      check_status("t3.clr", 2'd2, 1'b1, 1'b0, 0, 0);
      send_bad(1'b0);
      check_status("t3.b1", 2'd2, 1'b1, 1'b1, 1, 1);
      send_bad(1'b0);
      check_status("t3.b2", 2'd2, 1'b1, 1'b1, 2, 2);
      send_bad(1'b0);
      check_status("t3.b3", 2'd0, 1'b0, 1'b1, 3, 3);
      for (int i = 1; i <= 4; i++) begin
         send_clean();
         check_status("t3.resync", 2'd1, 1'b0, 1'b0, 3, 3);
      end
      send_clean();
      check_status("t3.relock", 2'd2, 1'b1, 1'b0, 3, 3);

      // 4: drop lock, zeros in HUNT are ignored, then lock on the 5th nonzero word
      for (int i = 0; i < 3; i++) send_bad(1'b0);
      check_status("t4.hunt", 2'd0, 1'b0, 1'b1, 6, 6);
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, 20'h00000, 1'b0);
         check_status("t4.zero", 2'd0, 1'b0, 1'b0, 6, 6);
      end
      for (int i = 1; i <= 4; i++) begin
         send_clean();
         check_status("t4.verify", 2'd1, 1'b0, 1'b0, 6, 6);
      end
      send_clean();
      check_status("t4.lock", 2'd2, 1'b1, 1'b0, 6, 6);

      // 5: err_count=2, then clear coincident with a mismatch
      apply(1'b0, 20'h00000, 1'b1);
      send_bad(1'b0);
      send_clean();
      send_bad(1'b0);
      check_status("t5.pre", 2'd2, 1'b1, 1'b1, 2, 3);
      send_bad(1'b1);
      check_status("t5.clr", 2'd2, 1'b1, 1'b1, 0, 0);
      send_clean();
      check_status("t5.post", 2'd2, 1'b1, 1'b0, 0, 1);

      // 6: gaps of 0..7 idle cycles carrying junk data
      for (int g = 0; g < 8; g++) begin
         send_clean();
         for (int k = 0; k < g; k++) begin
            apply(1'b0, 20'hABCDE, 1'b0);
            check_status("t6.gap", 2'd2, 1'b1, 1'b0, 0, 2 + g);
         end
         check_status("t6.word", 2'd2, 1'b1, 1'b0, 0, 2 + g);
      end

      // 6: asynchronous reset between edges, mid-word
      valid_i = 1'b1;
      lfsr_i  = gen;
      #3 reset = 1'b0;
      #1;
      check_status("t6.async", 2'd0, 1'b0, 1'b0, 0, 0);
      valid_i = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      check_status("t6.rel", 2'd0, 1'b0, 1'b0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         send_clean();
         check_status("t6.verify", 2'd1, 1'b0, 1'b0, 0, 0);
      end
      send_clean();
      check_status("t6.relock", 2'd2, 1'b1, 1'b0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive side of the 20-bit LFSR dither stream produced by the modulator's LFSR block.
- Self-synchronises to the incoming word sequence, declares lock, then flywheels its own prediction to detect and count corrupted words.
- Sits after the LFSR generator or after a loopback path in test builds.
- Gives a bit-exact integrity check of the dither source without file dumps.

Parameters:
- WIDTH, 20, LFSR word width.
- TAP_A, 19, first feedback tap index.
- TAP_B, 16, second feedback tap index (x^20+x^17+1, maximal length).
- LOCK_COUNT, 4, consecutive matches after seeding required to lock.
- LOSS_COUNT, 3, consecutive mismatches while locked that drop lock.
- CNT_W, 32, width of the error and word counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_i  in  1  lfsr_i carries a new word this cycle.
- lfsr_i  in  WIDTH  incoming LFSR word (signed in the datapath; compared as raw bits).
- clear_i  in  1  synchronous clear of the counters.
- locked_o  out  1  checker is in LOCKED.
- error_o  out  1  one-cycle pulse per mismatched word while locked.
- err_count_o  out  CNT_W  saturating mismatch count.
- word_count_o  out  CNT_W  saturating count of words checked while locked.
- state_o  out  2  current state encoding.

Behaviour:
- Step function: f(w) = {w[WIDTH-2:0], w[TAP_A]^w[TAP_B]}. The generator advances one step per valid word.
- Reset (reset=0, asynchronous) sets the following, with outputs going low immediately, not at the next edge:
  - state=HUNT, pred=0, match_cnt=0, miss_cnt=0.
  - All outputs = 0.
- valid_i=0: no state, counter or prediction change; error_o=0.
- All outputs are registered. The response to a word sampled at edge N is visible after edge N.
- HUNT (state_o=0):
  - Valid nonzero word: pred<=f(word), match_cnt<=0, go to VERIFY.
  - Zero word (lock-up value): ignored, stay in HUNT.
- VERIFY (state_o=1), on a valid word:
  - word==pred: pred<=f(word), match_cnt++. If match_cnt==LOCK_COUNT-1, go to LOCKED and set miss_cnt<=0.
  - Mismatch, word nonzero: reseed with pred<=f(word), match_cnt<=0, stay in VERIFY.
  - Mismatch, word zero: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED (state_o=2), on a valid word:
  - pred<=f(pred) (flywheel), so corrupted input never corrupts the prediction.
  - word_count++ (saturating).
  - Match: miss_cnt<=0.
  - Mismatch: error_o=1 for one cycle, err_count++ (saturating at all-ones), miss_cnt++.
  - If miss_cnt==LOSS_COUNT-1 on a mismatch, go to HUNT. locked_o falls on the same edge that pulses error_o.
- Encoding 3 is unused; it recovers to HUNT.
- clear_i=1 zeroes err_count and word_count. It takes priority over a coincident increment. State, pred and lock status are unaffected.
- Counters hold at 2^CNT_W-1 and never wrap.
- Comparison is full-width exact equality; the sign of lfsr_i is irrelevant.

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_WIDTH, TAP_A and TAP_B defaults.
  - The step function lfsr_next(w), so generator and checker share one polynomial definition.
  - The state encoding HUNT=0, VERIFY=1, LOCKED=2.
- One sub-module is natural: sat_counter (CNT_W, inc, clr, count), instantiated twice for the error and word counters.
- The FSM and prediction register stay in lfsr_checker.

Test Plan:
1. Reset release, then a generator seeded 20'h00001 streams words 00001, 00002, 00004, 00008, 00010 on consecutive valid cycles. Required response:
   - state_o goes 1 after the first word.
   - locked_o=1 after the 5th word.
   - err_count_o=0.
   - word_count_o=0, then increments from the 6th word.
2. Locked, stream word 00020 replaced by 00021. Required response:
   - error_o pulses exactly once and err_count_o=1.
   - locked_o stays 1.
   - Next word 00040 matches with no further error (flywheel check).
3. Locked, three consecutive corrupted words. Required response:
   - err_count_o=3.
   - locked_o=0 and state_o=0 after the third.
   - Clean stream resumes: relock after 5 valid words with err_count_o still 3.
4. In HUNT, feed 20'h00000 ×10, then a valid stream. Required response:
   - state_o stays 0 during the zeros.
   - No counts change.
   - Lock on the 5th nonzero word.
5. Locked with err_count_o=2, assert clear_i in the same cycle as a mismatched word. Required response:
   - err_count_o=0 and word_count_o=0.
   - error_o still pulses.
   - locked_o stays 1.
6. Gaps and reset: interleave valid_i=0 gaps of 0–7 cycles in a clean stream, then drive reset low mid-stream between clock edges. Required response:
   - Gaps: lock is unaffected and err_count_o stays 0.
   - Reset: all outputs 0 immediately.
   - After release: state_o=0, and relock takes 5 words.
